// File: rtl/sm83_bus_target.sv
// SM83-style bus target: a small memory window decoded from the latched address,
// with read drive, write capture/commit on wr_n release, and a sticky protocol-error flag.
module sm83_bus_target #(
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned BASE      = 'hFF80,
  parameter int unsigned SIZE_LOG2 = 7
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 t1,
  input  logic                 t2,
  input  logic                 t3,
  input  logic                 t4,
  input  logic [ADR_WIDTH-1:0] a,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic [WORD_SIZE-1:0] d_in,
  output logic [WORD_SIZE-1:0] d_out,
  output logic                 d_oe,
  output logic                 wr_commit,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int unsigned DEPTH = 2 ** SIZE_LOG2;
  localparam logic [ADR_WIDTH:0] BASE_X  = (ADR_WIDTH+1)'(BASE);
  localparam logic [ADR_WIDTH:0] LIMIT_X = BASE_X + (ADR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR, COMMIT} state_t;

  state_t                 state;
  logic [ADR_WIDTH-1:0]   a_q;
  logic                   hit_q;
  logic [WORD_SIZE-1:0]   data_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   mem [DEPTH];

  logic                   hit_a;
  logic [SIZE_LOG2-1:0]   idx_a;
  logic [SIZE_LOG2-1:0]   idx_q;
  logic                   both_low;
  logic                   commit_now;
  logic                   unused_phases;

  // t2..t4 are implied by the registered state; only t1 starts a decode
  assign unused_phases = t2 | t3 | t4;

  assign hit_a      = ({1'b0, a} >= BASE_X) && ({1'b0, a} < LIMIT_X);
  assign idx_a      = SIZE_LOG2'(a - BASE_X[ADR_WIDTH-1:0]);
  assign idx_q      = SIZE_LOG2'(a_q - BASE_X[ADR_WIDTH-1:0]);
  assign both_low   = !rd_n && !wr_n;
  assign commit_now = (state == WR) && wr_n;

  assign d_out = d_oe ? data_q : '0;

  // Store happens on the release edge so a read decoded at the very next t1 sees it
  always_ff @(posedge clk) begin
    if (commit_now) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      a_q       <= '0;
      hit_q     <= 1'b0;
      data_q    <= '0;
      wdata_q   <= '0;
      d_oe      <= 1'b0;
      wr_commit <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_commit <= 1'b0;
      if (t1) begin
        a_q   <= a;
        hit_q <= hit_a;
      end
      if (both_low) begin
        err   <= 1'b1;
        state <= IDLE;
        d_oe  <= 1'b0;
      end else begin
        if (err_clr) err <= 1'b0;
        if (commit_now) wr_commit <= 1'b1;
        if (t1) begin
          if (state == WR && !wr_n) err <= 1'b1;
          if (hit_a && !rd_n) begin
            state  <= RD;
            d_oe   <= 1'b1;
            data_q <= (commit_now && idx_q == idx_a) ? wdata_q : mem[idx_a];
          end else if (hit_a && !wr_n) begin
            state   <= WR;
            d_oe    <= 1'b0;
            wdata_q <= d_in;
          end else begin
            state <= IDLE;
            d_oe  <= 1'b0;
          end
        end else begin
          case (state)
            IDLE: if (hit_q && !wr_n) begin
              state   <= WR;
              wdata_q <= d_in;
            end
            RD: if (rd_n) begin
              state <= IDLE;
              d_oe  <= 1'b0;
            end
            WR: if (wr_n) state <= COMMIT;
                else      wdata_q <= d_in;
            COMMIT: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sm83_bus_target.sv
// Scoreboard bench for sm83_bus_target: a reference memory model predicts read data,
// queued at read issue and compared when the target starts driving the bus.
module tb_sm83_bus_target;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0;
  logic [15:0] a = '0;
  logic        rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]  d_in = '0;
  logic [7:0]  d_out;
  logic        d_oe, wr_commit, err;
  logic        err_clr = 1'b0;

  sm83_bus_target dut (
    .clk(clk), .n_reset(n_reset), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
    .a(a), .rd_n(rd_n), .wr_n(wr_n), .d_in(d_in), .d_out(d_out),
    .d_oe(d_oe), .wr_commit(wr_commit), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_commit = 0, exp_commit = 0;
  logic [7:0] model [128];
  logic [7:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: count commit pulses, pop scoreboard on the first drive phase, d_out quiet when not driving
  always @(negedge clk) begin
    if (wr_commit) n_commit++;
    if (!d_oe) chk("d_out_idle", d_out, 0);
    else if (t2) begin
      if (sb.size() == 0) chk("unexpected_read", 1, 0);
      else chk("rd_data", d_out, sb.pop_front());
    end
  end

  task automatic ph(input int p, input logic rdn, input logic wrn,
                    input logic [15:0] addr, input logic [7:0] din);
    t1 = (p == 1); t2 = (p == 2); t3 = (p == 3); t4 = (p == 4);
    rd_n = rdn; wr_n = wrn; a = addr; d_in = din;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input bit two_beat);
    ph(1, 1, 1, addr, 8'h00);
    ph(2, 1, two_beat ? 1'b0 : 1'b1, addr, two_beat ? ~data : 8'h00);
    ph(3, 1, 0, addr, data);
    ph(4, 1, 1, addr, 8'hFF);
    chk("wr_commit", wr_commit, 1);
    exp_commit++;
    model[addr[6:0]] = data;
  endtask

  task automatic do_read(input logic [15:0] addr, input bit exp_hit);
    if (exp_hit) sb.push_back(model[addr[6:0]]);
    ph(1, 0, 1, addr, 8'h00); chk("rd_oe_t2", d_oe, exp_hit);
    ph(2, 0, 1, addr, 8'h00); chk("rd_oe_t3", d_oe, exp_hit);
    ph(3, 0, 1, addr, 8'h00); chk("rd_oe_t4", d_oe, exp_hit);
    ph(4, 0, 1, addr, 8'h00);
  endtask

  task automatic idle_cycle();
    ph(1, 1, 1, 16'h0000, 0); ph(2, 1, 1, 16'h0000, 0);
    ph(3, 1, 1, 16'h0000, 0); ph(4, 1, 1, 16'h0000, 0);
  endtask

  initial begin
    // Reset state, then release mid-cycle: a write strobe before the next t1 must be ignored
    ph(1, 1, 1, 16'hFF85, 0); ph(2, 1, 1, 16'hFF85, 0);
    chk("rst_d_oe", d_oe, 0); chk("rst_d_out", d_out, 0);
    chk("rst_wr_commit", wr_commit, 0); chk("rst_err", err, 0);
    n_reset = 1'b1;
    ph(3, 1, 0, 16'hFF85, 8'h55); ph(4, 1, 1, 16'hFF85, 0);
    chk("no_decode_before_t1", n_commit, 0);
    idle_cycle();

    // Write then immediate read of the same location
    do_write(16'hFF85, 8'hA5, 0);
    do_read(16'hFF85, 1);
    chk("commits_a5", n_commit, exp_commit);

    // Window edges
    do_read(16'hFF7F, 0);
    chk("miss_err", err, 0);
    do_write(16'hFFFF, 8'h3C, 0);
    do_read(16'hFFFF, 1);

    // Back-to-back writes, second with an earlier beat that must be overwritten
    do_write(16'hFF80, 8'h01, 0);
    do_write(16'hFF80, 8'h02, 1);
    do_read(16'hFF80, 1);
    chk("commits_b2b", n_commit, exp_commit);

    // Both strobes low: error, no drive, no store; then clear, then clear vs set collision
    ph(1, 1, 1, 16'hFF85, 0);
    ph(2, 0, 0, 16'hFF85, 8'h66);
    chk("both_err", err, 1); chk("both_d_oe", d_oe, 0);
    ph(3, 1, 1, 16'hFF85, 0); ph(4, 1, 1, 16'hFF85, 0);
    err_clr = 1'b1; ph(1, 1, 1, 16'h0000, 0); err_clr = 1'b0;
    chk("err_clr", err, 0);
    err_clr = 1'b1; ph(2, 0, 0, 16'h0000, 0); err_clr = 1'b0;
    chk("err_set_wins", err, 1);
    ph(3, 1, 1, 16'h0000, 0); ph(4, 1, 1, 16'h0000, 0);
    err_clr = 1'b1; ph(1, 1, 1, 16'h0000, 0); err_clr = 1'b0;
    chk("err_clr2", err, 0);
    ph(2, 1, 1, 16'h0000, 0); ph(3, 1, 1, 16'h0000, 0); ph(4, 1, 1, 16'h0000, 0);
    do_read(16'hFF85, 1);
    chk("commits_both", n_commit, exp_commit);

    // Write held across t1 is aborted
    do_write(16'hFF86, 8'h11, 0);
    ph(1, 1, 1, 16'hFF86, 0); ph(2, 1, 1, 16'hFF86, 0);
    ph(3, 1, 0, 16'hFF86, 8'h99); ph(4, 1, 0, 16'hFF86, 8'h99);
    ph(1, 1, 0, 16'h0000, 8'h99);
    chk("abort_err", err, 1);
    ph(2, 1, 1, 16'h0000, 0); ph(3, 1, 1, 16'h0000, 0); ph(4, 1, 1, 16'h0000, 0);
    chk("abort_commits", n_commit, exp_commit);
    do_read(16'hFF86, 1);

    // Reset in the middle of a write discards it; outputs clear without a clock edge
    do_write(16'hFF90, 8'h5A, 0);
    chk("err_pre_rst", err, 1);
    ph(1, 1, 1, 16'hFF90, 0); ph(2, 1, 1, 16'hFF90, 0);
    ph(3, 1, 0, 16'hFF90, 8'hEE);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_err", err, 0); chk("arst_d_oe", d_oe, 0);
    chk("arst_d_out", d_out, 0); chk("arst_wr_commit", wr_commit, 0);
    ph(4, 1, 1, 16'hFF90, 0);
    ph(1, 1, 1, 16'h0000, 0);
    n_reset = 1'b1;
    ph(2, 1, 1, 16'h0000, 0); ph(3, 1, 1, 16'h0000, 0); ph(4, 1, 1, 16'h0000, 0);
    do_read(16'hFF90, 1);
    do_read(16'hFFFF, 1);
    idle_cycle();

    chk("final_commits", n_commit, exp_commit);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sm83_bus_target.md
SM83_BUS_TARGET -- requirements
Module: sm83_bus_target

Interface
REQ-001 Parameter ADR_WIDTH, default 16, address bus width.
REQ-002 Parameter WORD_SIZE, default 8, data bus width.
REQ-003 Parameter BASE, default 16'hFF80, first address of decoded window.
REQ-004 Parameter SIZE_LOG2, default 7, window/storage size is 2**SIZE_LOG2 words.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 n_reset  input  1  reset, asynchronous, active-low.
REQ-007 t1, t2, t3, t4  input  1 each  machine-cycle phase strobes, exactly one high per clk.
REQ-008 a  input  ADR_WIDTH  address pins from initiator.
REQ-009 rd_n  input  1  read strobe, active-low.
REQ-010 wr_n  input  1  write strobe, active-low.
REQ-011 d_in  input  WORD_SIZE  data pins as driven by initiator.
REQ-012 d_out  output  WORD_SIZE  read data toward initiator.
REQ-013 d_oe  output  1  d_out drive enable.
REQ-014 wr_commit  output  1  one-clk pulse when a write is stored.
REQ-015 err  output  1  sticky protocol-error flag.
REQ-016 err_clr  input  1  synchronous clear of err.

Function
REQ-017 hit SHALL be true when BASE <= a_q < BASE + 2**SIZE_LOG2, a_q being address latched at posedge with t1 high; index = a_q - BASE, SIZE_LOG2 bits.
REQ-018 Storage SHALL be 2**SIZE_LOG2 x WORD_SIZE, not cleared by reset.
REQ-019 FSM states SHALL be IDLE, RD, WR, COMMIT; every cycle boundary (t1) re-evaluates from IDLE-equivalent decisions below.
REQ-020 At posedge with t1: latch a; if hit and rd_n low and wr_n high -> RD, data_q <= mem[index].
REQ-021 In RD, d_oe SHALL be 1 and d_out = data_q during the t2, t3, t4 phases of that machine cycle; d_oe SHALL drop at the next t1 posedge or the first posedge rd_n samples high, whichever first.
REQ-022 From IDLE, posedge with wr_n low and hit latched -> WR; in WR d_in SHALL be captured into wdata_q every clk wr_n is low.
REQ-023 In WR, first posedge with wr_n high -> COMMIT; COMMIT writes wdata_q to mem[index], pulses wr_commit for exactly one clk, then IDLE.
REQ-024 Last captured value wins: data sampled while wr_n low, never after release.
REQ-025 If t1 posedge arrives while in WR (wr_n never released), write SHALL be aborted (no store, no wr_commit), err set, new cycle decoded normally.
REQ-026 rd_n and wr_n both low at any posedge: err set, d_oe forced 0, no store; FSM -> IDLE.
REQ-027 Miss (hit false): d_oe stays 0, no store, no error.
REQ-028 Write followed by read of same index in next machine cycle SHALL return new data (COMMIT completes before next t1+1).
REQ-029 err SHALL stay set until err_clr; if set condition and err_clr coincide, err ends set.
REQ-030 d_out SHALL be 0 whenever d_oe is 0.

Reset
REQ-031 n_reset low SHALL immediately force state IDLE, d_oe 0, d_out 0, wr_commit 0, err 0, a_q 0, wdata_q 0, data_q 0.
REQ-032 Reset asserted mid-WR SHALL discard the pending write; storage otherwise unchanged.
REQ-033 After n_reset rises, first cycle decode SHALL wait for next t1.

Verification
REQ-034 Write 8'hA5 to FF85 (wr_n low in t3, released t4) -> wr_commit one pulse, mem[5]=8'hA5; next cycle read FF85 -> d_oe 1 t2..t4, d_out 8'hA5.
REQ-035 Read FF7F and FFFF with BASE FF80, SIZE_LOG2 7 -> FFFF hits index 7F; FF7F d_oe 0, err 0.
REQ-036 rd_n and wr_n low together at t2 -> err 1, d_oe 0, no store; err_clr pulse -> err 0.
REQ-037 wr_n held low across t1 -> no wr_commit, storage unchanged, err 1.
REQ-038 n_reset low during t3 of write to FF90 -> outputs zero asynchronously, mem[10] retains prior value, no wr_commit.
REQ-039 Back-to-back writes FF80=8'h01, FF80=8'h02 -> two wr_commit pulses, final read 8'h02.
